pixel_xy_counter: RTL and testbench
===================================

# pixel_xy_counter

Parametrised 2-D pixel address generator for the camera datapath. It replaces plain single-width enable counters wherever the design needs a column, row and linear frame-buffer address together. It advances one pixel per enabled clock, wraps at a runtime-programmable line length and frame height, and flags end-of-line and end-of-frame. Capture, frame-buffer write and VGA read-out each instantiate one.

## Interface
Parameters:
- XW, 10, width of column count and `h_len`
- YW, 9, width of row count and `v_len`
- AW, 17, width of linear address
- H_DEF, 320, line length loaded at reset
- V_DEF, 240, frame height loaded at reset
- FW, 8, width of frame counter (only with macro)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- en  in  1  advance one pixel
- clr  in  1  synchronous restart to pixel (0,0)
- h_len  in  XW  pixels per line, sampled at shadow load
- v_len  in  YW  lines per frame, sampled at shadow load
- x  out  XW  current column
- y  out  YW  current row
- addr  out  AW  linear address
- eol  out  1  level: x is last column
- eof  out  1  level: x and y are last column and row
- frame_done  out  1  one-cycle pulse after frame wrap
- frame_cnt  out  FW  completed frames (macro only)

## Operation
- Shadow registers `hq`/`vq` hold the active lengths. They load from `h_len`/`v_len` on `clr` and on every frame wrap. Runtime changes take effect only at a frame boundary.
- A length input of 0 loads as 1. No other clamping is applied.
- Advance (`en`=1, `clr`=0):
  - x < hq-1: x+1, addr+1.
  - x = hq-1, y < vq-1: x←0, y+1, addr+1.
  - x = hq-1, y = vq-1 (frame wrap): x←0, y←0, addr←0, shadow load, frame_done←1.
- `addr` wraps modulo 2^AW when hq·vq exceeds 2^AW. This is not an error.
- `clr`=1: x, y and addr go to 0, shadow load, frame_done←0. `clr` wins over `en` in the same cycle. frame_cnt is unaffected.
- `en`=0: all state holds; frame_done←0.
- If a shadow load lowers the lengths below the current x/y, the stale state cannot occur. Shadow loads happen only when x = y = 0.
- `eol` = (x == hq-1), decoded from registers with no `en` dependency.
- `eof` = `eol` & (y == vq-1).
- With hq=1 or vq=1 these flags are permanently or frequently high as the decode dictates.
- States are implicit (ACTIVE only). No FSM beyond the counters.

## Timing
- Reset values:
  - x = 0, y = 0, addr = 0, frame_done = 0, frame_cnt = 0.
  - hq = H_DEF, vq = V_DEF.
  - eol/eof are decoded from these values: both 0 for the default parameters.
- Latency: x/y/addr update on the edge where `en` is sampled high, so there is 1 cycle from `en` to new value.
- frame_done is registered. It is high for exactly one cycle, coincident with x = y = addr = 0 after a wrap.
- Back-to-back wraps (hq = vq = 1, `en` held high): frame_done stays high every cycle.
- Reset assertion mid-frame clears immediately, asynchronously, regardless of clk. Release is synchronous to the next edge by upstream design.

## Configuration
- Macro `PIXEL_XY_FRAME_CNT_EN`.
- Defined:
  - `frame_cnt` port exists.
  - Increments by 1 (mod 2^FW) on each frame wrap, coincident with frame_done.
  - Cleared only by reset.
- Undefined:
  - Port and register are absent.
  - All other behaviour is identical.

## Test plan
- Reset with H_DEF=4, V_DEF=3, `en` high for 12 cycles:
  - x steps 0,1,2,3,0…; y steps 0..2; addr steps 0..11.
  - eol is high at x=3; eof is high only at addr=11.
  - frame_done pulses on cycle 13 with addr=0.
- Write h_len=2, v_len=2 mid-frame:
  - The current frame still ends at addr 11.
  - The next frame wraps after 4 advances.
  - frame_cnt = 2 after the second wrap (macro on).
- `clr` and `en` high together at addr=7:
  - Next cycle x=y=addr=0 and frame_done=0.
  - h_len/v_len are captured.
- h_len=0, v_len=1, `en` held high:
  - x stays 0; eol=eof=1 constantly.
  - frame_done is high every cycle after the first advance.
- AW=3, 4×3 frame:
  - addr sequence is 0..7,0..3, then 0 at the frame wrap.
- Assert reset asynchronously at x=2, y=1 between clock edges:
  - Outputs are zero immediately.
  - hq/vq return to 4/3.

Source files
------------

// File: rtl/pixel_xy_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_xy_counter : 2-D pixel address generator with shadowed line/frame size.
// Optional frame counter enabled by macro PIXEL_XY_FRAME_CNT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module pixel_xy_counter #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int AW    = 17,
  parameter int H_DEF = 320,
  parameter int V_DEF = 240,
  parameter int FW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic [XW-1:0] h_len,
  input  logic [YW-1:0] v_len,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic          eol,
  output logic          eof,
  output logic          frame_done
`ifdef PIXEL_XY_FRAME_CNT_EN
  ,
  output logic [FW-1:0] frame_cnt
`endif
);

  localparam logic [XW-1:0] C_H_RST = XW'(H_DEF);
  localparam logic [YW-1:0] C_V_RST = YW'(V_DEF);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [XW-1:0] hq_q, hq_d;
  logic [YW-1:0] vq_q, vq_d;
  logic          frame_done_q, frame_done_d;
  logic [XW-1:0] h_load;
  logic [YW-1:0] v_load;

`ifdef PIXEL_XY_FRAME_CNT_EN
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
`endif

  // A zero length would make the last-index decode underflow, so it loads as 1.
  assign h_load = (h_len == '0) ? XW'(1) : h_len;
  assign v_load = (v_len == '0) ? YW'(1) : v_len;

  assign eol = (x_q == hq_q - XW'(1));
  assign eof = eol && (y_q == vq_q - YW'(1));

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    hq_d         = hq_q;
    vq_d         = vq_q;
    frame_done_d = 1'b0;
`ifdef PIXEL_XY_FRAME_CNT_EN
    frame_cnt_d  = frame_cnt_q;
`endif
    if (clr) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
      hq_d   = h_load;
      vq_d   = v_load;
    end else if (en) begin
      if (!eol) begin
        x_d    = x_q + XW'(1);
        addr_d = addr_q + AW'(1);
      end else if (!eof) begin
        x_d    = '0;
        y_d    = y_q + YW'(1);
        addr_d = addr_q + AW'(1);
      end else begin
        // Frame wrap: new lengths are only adopted here, where x = y = 0.
        x_d          = '0;
        y_d          = '0;
        addr_d       = '0;
        hq_d         = h_load;
        vq_d         = v_load;
        frame_done_d = 1'b1;
`ifdef PIXEL_XY_FRAME_CNT_EN
        frame_cnt_d  = frame_cnt_q + FW'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      hq_q         <= C_H_RST;
      vq_q         <= C_V_RST;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      hq_q         <= hq_d;
      vq_q         <= vq_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef PIXEL_XY_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign x          = x_q;
  assign y          = y_q;
  assign addr       = addr_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_xy_counter.sv
`default_nettype none
// Directed testbench for pixel_xy_counter: 4x3 default frame plus a 3-bit address instance.
module tb_pixel_xy_counter;

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int AW = 17;

  logic          clk;
  logic          reset;
  logic          en, clr;
  logic [XW-1:0] h_len;
  logic [YW-1:0] v_len;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] addr;
  logic          eol, eof, frame_done;

  logic          en3, clr3;
  logic [XW-1:0] x3;
  logic [YW-1:0] y3;
  logic [2:0]    addr3;
  logic          eol3, eof3, fd3;

`ifdef PIXEL_XY_FRAME_CNT_EN
  logic [7:0] frame_cnt, frame_cnt3;
`endif

  int checks = 0;
  int errors = 0;

  pixel_xy_counter #(.XW(XW), .YW(YW), .AW(AW), .H_DEF(4), .V_DEF(3), .FW(8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .h_len(h_len), .v_len(v_len),
    .x(x), .y(y), .addr(addr), .eol(eol), .eof(eof), .frame_done(frame_done)
`ifdef PIXEL_XY_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  pixel_xy_counter #(.XW(XW), .YW(YW), .AW(3), .H_DEF(4), .V_DEF(3), .FW(8)) u_dut3 (
    .clk(clk), .reset(reset), .en(en3), .clr(clr3), .h_len(10'd4), .v_len(9'd3),
    .x(x3), .y(y3), .addr(addr3), .eol(eol3), .eof(eof3), .frame_done(fd3)
`ifdef PIXEL_XY_FRAME_CNT_EN
    , .frame_cnt(frame_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    en = 1'b1;
    repeat (3) step();
    checks++;
    if ({x, y, addr, eol, eof, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset got x=%0d y=%0d addr=%0d eol=%b eof=%b fd=%b required all zero",
               x, y, addr, eol, eof, frame_done);
    end
    checks++;
    if ({x3, y3, addr3, fd3} !== '0) begin
      errors++;
      $display("FAIL reset_narrow got x=%0d y=%0d addr=%0d fd=%b required all zero", x3, y3, addr3, fd3);
    end
    en = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_frame_walk();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (x !== XW'(i % 4) || y !== YW'(i / 4) || addr !== AW'(i) ||
          eol !== (i % 4 == 3) || eof !== (i == 11) || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL walk i=%0d got x=%0d y=%0d addr=%0d eol=%b eof=%b fd=%b required x=%0d y=%0d addr=%0d",
                 i, x, y, addr, eol, eof, frame_done, i % 4, i / 4, i);
      end
      step();
    end
    checks++;
    if ({x, y, addr} !== '0 || frame_done !== 1'b1 || eol !== 1'b0) begin
      errors++;
      $display("FAIL walk_wrap got x=%0d y=%0d addr=%0d fd=%b eol=%b required 0/0/0 fd=1 eol=0",
               x, y, addr, frame_done, eol);
    end
  endtask

  task automatic test_length_change();
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        h_len = 10'd2;
        v_len = 9'd2;
      end
      checks++;
      if (x !== XW'(i % 4) || y !== YW'(i / 4) || addr !== AW'(i) ||
          eol !== (i % 4 == 3) || eof !== (i == 11) || frame_done !== (i == 0)) begin
        errors++;
        $display("FAIL old_len i=%0d got x=%0d y=%0d addr=%0d eol=%b eof=%b fd=%b required x=%0d y=%0d addr=%0d",
                 i, x, y, addr, eol, eof, frame_done, i % 4, i / 4, i);
      end
      step();
    end
`ifdef PIXEL_XY_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 8'd2) begin
      errors++;
      $display("FAIL frame_cnt_2 got %0d required 2", frame_cnt);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (x !== XW'(i % 2) || y !== YW'(i / 2) || addr !== AW'(i) ||
          eol !== (i % 2 == 1) || eof !== (i == 3) || frame_done !== (i == 0)) begin
        errors++;
        $display("FAIL new_len i=%0d got x=%0d y=%0d addr=%0d eol=%b eof=%b fd=%b required x=%0d y=%0d addr=%0d",
                 i, x, y, addr, eol, eof, frame_done, i % 2, i / 2, i);
      end
      step();
    end
    checks++;
    if ({x, y, addr} !== '0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL new_len_wrap got x=%0d y=%0d addr=%0d fd=%b required 0/0/0 fd=1", x, y, addr, frame_done);
    end
`ifdef PIXEL_XY_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 8'd3) begin
      errors++;
      $display("FAIL frame_cnt_3 got %0d required 3", frame_cnt);
    end
`endif
  endtask

  task automatic test_clr_en();
    en = 1'b0;
    clr = 1'b1;
    h_len = 10'd4;
    v_len = 9'd3;
    step();
    clr = 1'b0;
    checks++;
    if ({x, y, addr} !== '0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_only got x=%0d y=%0d addr=%0d fd=%b required 0/0/0 fd=0", x, y, addr, frame_done);
    end
    en = 1'b1;
    repeat (7) step();
    checks++;
    if (x !== XW'(3) || y !== YW'(1) || addr !== AW'(7) || eol !== 1'b1) begin
      errors++;
      $display("FAIL pre_clr got x=%0d y=%0d addr=%0d eol=%b required 3/1/7 eol=1", x, y, addr, eol);
    end
    h_len = 10'd3;
    v_len = 9'd2;
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if ({x, y, addr} !== '0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_en got x=%0d y=%0d addr=%0d fd=%b required 0/0/0 fd=0", x, y, addr, frame_done);
    end
`ifdef PIXEL_XY_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 8'd3) begin
      errors++;
      $display("FAIL clr_keeps_cnt got %0d required 3", frame_cnt);
    end
`endif
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (x !== XW'(i % 3) || y !== YW'(i / 3) || addr !== AW'(i) ||
          eol !== (i % 3 == 2) || eof !== (i == 5) || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL clr_len i=%0d got x=%0d y=%0d addr=%0d eol=%b eof=%b required x=%0d y=%0d addr=%0d",
                 i, x, y, addr, eol, eof, i % 3, i / 3, i);
      end
      step();
    end
    checks++;
    if ({x, y, addr} !== '0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL clr_len_wrap got x=%0d y=%0d addr=%0d fd=%b required 0/0/0 fd=1", x, y, addr, frame_done);
    end
    en = 1'b0;
    step();
    checks++;
    if ({x, y, addr} !== '0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL hold_fd got addr=%0d fd=%b required addr=0 fd=0", addr, frame_done);
    end
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (2) step();
    checks++;
    if (x !== XW'(1) || addr !== AW'(1) || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL hold got x=%0d addr=%0d fd=%b required x=1 addr=1 fd=0", x, addr, frame_done);
    end
  endtask

  task automatic test_degenerate();
    h_len = 10'd0;
    v_len = 9'd1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if ({x, y, addr} !== '0 || eol !== 1'b1 || eof !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL degen_load got x=%0d addr=%0d eol=%b eof=%b fd=%b required 0/0 1/1/0",
               x, addr, eol, eof, frame_done);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({x, y, addr} !== '0 || eol !== 1'b1 || eof !== 1'b1 || frame_done !== 1'b1) begin
        errors++;
        $display("FAIL degen i=%0d got x=%0d addr=%0d eol=%b eof=%b fd=%b required 0/0 1/1/1",
                 i, x, addr, eol, eof, frame_done);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_narrow_addr();
    en3 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (addr3 !== 3'(i % 8) || x3 !== XW'(i % 4) || y3 !== YW'(i / 4)) begin
        errors++;
        $display("FAIL narrow i=%0d got addr=%0d x=%0d y=%0d required addr=%0d x=%0d y=%0d",
                 i, addr3, x3, y3, i % 8, i % 4, i / 4);
      end
      step();
    end
    checks++;
    if (addr3 !== 3'd0 || fd3 !== 1'b1) begin
      errors++;
      $display("FAIL narrow_wrap got addr=%0d fd=%b required addr=0 fd=1", addr3, fd3);
    end
    en3 = 1'b0;
  endtask

  task automatic test_async_reset();
    h_len = 10'd5;
    v_len = 9'd2;
    clr = 1'b1;
    step();
    clr = 1'b0;
    en = 1'b1;
    repeat (7) step();
    en = 1'b0;
    checks++;
    if (x !== XW'(2) || y !== YW'(1) || addr !== AW'(7)) begin
      errors++;
      $display("FAIL pre_reset got x=%0d y=%0d addr=%0d required 2/1/7", x, y, addr);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({x, y, addr, eol, eof, frame_done} !== '0) begin
      errors++;
      $display("FAIL async_reset got x=%0d y=%0d addr=%0d eol=%b eof=%b fd=%b required all zero",
               x, y, addr, eol, eof, frame_done);
    end
    #1 reset = 1'b1;
    step();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (x !== XW'(i % 4) || y !== YW'(i / 4) || addr !== AW'(i) ||
          eol !== (i % 4 == 3) || eof !== (i == 11)) begin
        errors++;
        $display("FAIL post_reset i=%0d got x=%0d y=%0d addr=%0d eol=%b eof=%b required x=%0d y=%0d addr=%0d",
                 i, x, y, addr, eol, eof, i % 4, i / 4, i);
      end
      step();
    end
    checks++;
    if ({x, y, addr} !== '0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_wrap got x=%0d y=%0d addr=%0d fd=%b required 0/0/0 fd=1", x, y, addr, frame_done);
    end
`ifdef PIXEL_XY_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL post_reset_cnt got %0d required 1", frame_cnt);
    end
`endif
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    clr   = 1'b0;
    en3   = 1'b0;
    clr3  = 1'b0;
    h_len = 10'd4;
    v_len = 9'd3;
    test_reset();
    test_frame_walk();
    test_length_change();
    test_clr_en();
    test_degenerate();
    test_narrow_addr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
